video_zone_sampler: RTL and testbench

VIDEO_ZONE_SAMPLER -- requirements
Module: video_zone_sampler

---
 rtl/video_zone_sampler.sv | 153 +++++++++++++++
 tb/tb_video_zone_sampler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_zone_sampler.sv
// ============================================================================
// video_zone_sampler: decimating pixel sampler with frame-geometry checking
// Rev 1.0
// ============================================================================
`default_nettype none

module video_zone_sampler #(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int H_DECIM  = 8,
  parameter int V_DECIM  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        vs,
  input  logic        de,
  input  logic [23:0] rgb,
  output logic        data_en,
  output logic [23:0] data,
  output logic        frame_done,
  output logic        frame_err
);

  localparam logic [11:0] C_H_ACT  = 12'(H_ACTIVE);
  localparam logic [10:0] C_V_ACT  = 11'(V_ACTIVE);
  localparam logic [5:0]  C_H_LAST = 6'(H_DECIM - 1);
  localparam logic [5:0]  C_V_LAST = 6'(V_DECIM - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        vs_d1_q, vs_d1_d;
  logic        de_d1_q, de_d1_d;
  logic [11:0] pix_cnt_q, pix_cnt_d;
  logic [10:0] line_cnt_q, line_cnt_d;
  logic [5:0]  h_phase_q, h_phase_d;
  logic [5:0]  v_phase_q, v_phase_d;
  logic        line_err_q, line_err_d;
  logic        data_en_q, data_en_d;
  logic [23:0] data_q, data_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;

  logic        frame_start;
  logic        line_end;
  logic        sample;

  assign frame_start = vs & ~vs_d1_q;
  assign line_end    = de_d1_q & ~de;

  always_comb begin
    state_d      = state_q;
    vs_d1_d      = vs;
    de_d1_d      = de;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    h_phase_d    = h_phase_q;
    v_phase_d    = v_phase_q;
    line_err_d   = line_err_q;
    data_en_d    = 1'b0;
    data_d       = data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    sample       = 1'b0;

    // A line that ends on the same cycle as a frame start still belongs to the closing frame
    if (state_q == ACTIVE && line_end) begin
      if (pix_cnt_q != C_H_ACT) line_err_d = 1'b1;
      pix_cnt_d  = 12'd0;
      h_phase_d  = 6'd0;
      line_cnt_d = (line_cnt_q == 11'h7FF) ? line_cnt_q : line_cnt_q + 11'd1;
      v_phase_d  = (v_phase_q == C_V_LAST) ? 6'd0 : v_phase_q + 6'd1;
    end

    case (state_q)
      IDLE: begin
        if (en) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (frame_start) state_d = en ? ACTIVE : IDLE;
      end
      ACTIVE: begin
        if (frame_start) begin
          if (line_cnt_d == C_V_ACT && !line_err_d) frame_done_d = 1'b1;
          else                                      frame_err_d  = 1'b1;
          if (!en) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_start) begin
      pix_cnt_d  = 12'd0;
      line_cnt_d = 11'd0;
      h_phase_d  = 6'd0;
      v_phase_d  = 6'd0;
      line_err_d = 1'b0;
    end

    // Counting after the clear puts a pixel coincident with frame start into the new frame
    if (state_d == ACTIVE && de) begin
      sample    = (h_phase_d == 6'd0) && (v_phase_d == 6'd0) &&
                  (pix_cnt_d < C_H_ACT) && (line_cnt_d < C_V_ACT);
      data_en_d = sample;
      if (sample) data_d = rgb;
      pix_cnt_d = (pix_cnt_d == 12'hFFF) ? pix_cnt_d : pix_cnt_d + 12'd1;
      h_phase_d = (h_phase_d == C_H_LAST) ? 6'd0 : h_phase_d + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vs_d1_q      <= 1'b0;
      de_d1_q      <= 1'b0;
      pix_cnt_q    <= 12'd0;
      line_cnt_q   <= 11'd0;
      h_phase_q    <= 6'd0;
      v_phase_q    <= 6'd0;
      line_err_q   <= 1'b0;
      data_en_q    <= 1'b0;
      data_q       <= 24'h0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_d1_q      <= vs_d1_d;
      de_d1_q      <= de_d1_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      h_phase_q    <= h_phase_d;
      v_phase_q    <= v_phase_d;
      line_err_q   <= line_err_d;
      data_en_q    <= data_en_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_en    = data_en_q;
  assign data       = data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_video_zone_sampler.sv
// ============================================================================
// tb_video_zone_sampler: directed frames into decim-4 and decim-1 instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_video_zone_sampler;

  logic        clk = 1'b0;
  logic        rst_n, en, vs, de;
  logic [23:0] rgb;

  logic        d4_en, d4_done, d4_err;
  logic [23:0] d4_data;
  logic        d1_en, d1_done, d1_err;
  logic [23:0] d1_data;

  always #5 clk = ~clk;

  video_zone_sampler #(.H_ACTIVE(16), .V_ACTIVE(8), .H_DECIM(4), .V_DECIM(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .vs(vs), .de(de), .rgb(rgb),
    .data_en(d4_en), .data(d4_data), .frame_done(d4_done), .frame_err(d4_err)
  );

  video_zone_sampler #(.H_ACTIVE(16), .V_ACTIVE(8), .H_DECIM(1), .V_DECIM(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .vs(vs), .de(de), .rgb(rgb),
    .data_en(d1_en), .data(d1_data), .frame_done(d1_done), .frame_err(d1_err)
  );

  typedef struct {
    int          dut;
    int          cyc;
    logic [23:0] d;
  } samp_t;

  typedef struct {
    int dut;
    int cyc;
    int kind;   // 1 = done, 2 = err
  } pulse_t;

  samp_t  sq[$];
  pulse_t pq[$];
  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  bit     mon_on   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic mon_dut(input int i, input logic den, input logic [23:0] dd,
                         input logic fd, input logic fe);
    int idx;
    if (den === 1'b1) begin
      idx = -1;
      foreach (sq[k]) if (idx < 0 && sq[k].dut == i) idx = k;
      if (idx < 0) chk($sformatf("unexpected_data_en_dut%0d", i), {31'b0, den}, 32'd0);
      else begin
        chk($sformatf("data_dut%0d", i), {8'b0, dd}, {8'b0, sq[idx].d});
        chk($sformatf("data_latency_dut%0d", i), cyc, sq[idx].cyc);
        sq.delete(idx);
      end
    end
    if (fd === 1'b1 || fe === 1'b1) begin
      idx = -1;
      foreach (pq[k]) if (idx < 0 && pq[k].dut == i) idx = k;
      if (idx < 0) chk($sformatf("unexpected_pulse_dut%0d", i), {30'b0, fd, fe}, 32'd0);
      else begin
        chk($sformatf("pulse_kind_dut%0d", i), {30'b0, fd, fe},
            (pq[idx].kind == 1) ? 32'd2 : 32'd1);
        chk($sformatf("pulse_cyc_dut%0d", i), cyc, pq[idx].cyc);
        pq.delete(idx);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon_dut(0, d4_en, d4_data, d4_done, d4_err);
      mon_dut(1, d1_en, d1_data, d1_done, d1_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_d4_data_en"}, {31'b0, d4_en}, 32'd0);
    chk({tag, "_d4_data"}, {8'b0, d4_data}, 32'd0);
    chk({tag, "_d4_done"}, {31'b0, d4_done}, 32'd0);
    chk({tag, "_d4_err"}, {31'b0, d4_err}, 32'd0);
    chk({tag, "_d1_data_en"}, {31'b0, d1_en}, 32'd0);
    chk({tag, "_d1_data"}, {8'b0, d1_data}, 32'd0);
    chk({tag, "_d1_done"}, {31'b0, d1_done}, 32'd0);
    chk({tag, "_d1_err"}, {31'b0, d1_err}, 32'd0);
  endtask

  // Expected samples from the spec geometry: 16x8 window, decim 4 vs decim 1
  task automatic push_samp(input bit samp, input int x, input int y, input logic [23:0] v);
    samp_t s;
    if (samp && x < 16 && y < 8) begin
      s.cyc = cyc + 1;
      s.d   = v;
      if (x % 4 == 0 && y % 4 == 0) begin
        s.dut = 0;
        sq.push_back(s);
      end
      s.dut = 1;
      sq.push_back(s);
    end
  endtask

  function automatic logic [23:0] pixval(input int fid, input int y, input int x);
    return {4'hA, 4'(fid), 8'(y), 8'(x)};
  endfunction

  task automatic frame(input int exp_pulse, input bit co_de, input int lines, input int pix,
                       input int short_line, input int rst_line, input int en_drop,
                       input bit samp_in, input int fid);
    bit     samp;
    int     len;
    int     x0;
    pulse_t p;
    samp = samp_in;
    step();
    vs = 1'b1;
    de = co_de;
    if (exp_pulse != 0) begin
      p.cyc  = cyc + 1;
      p.kind = exp_pulse;
      p.dut  = 0;
      pq.push_back(p);
      p.dut  = 1;
      pq.push_back(p);
    end
    if (co_de) begin
      rgb = pixval(fid, 0, 0);
      push_samp(samp, 0, 0, rgb);
    end else begin
      repeat (3) begin
        step();
        vs = 1'b0;
        de = 1'b0;
      end
    end
    for (int y = 0; y < lines; y++) begin
      if (y == rst_line) begin
        step();
        rst_n = 1'b0;
        vs    = 1'b0;
        de    = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("midframe_reset");
        samp = 1'b0;
      end
      if (y == en_drop) en = 1'b0;
      len = (y == short_line) ? pix - 1 : pix;
      x0  = (co_de && y == 0) ? 1 : 0;
      for (int x = x0; x < len; x++) begin
        step();
        vs  = 1'b0;
        de  = 1'b1;
        rgb = pixval(fid, y, x);
        push_samp(samp, x, y, rgb);
      end
      repeat (4) begin
        step();
        vs = 1'b0;
        de = 1'b0;
      end
    end
    repeat (3) begin
      step();
      vs = 1'b0;
      de = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    vs    = 1'b0;
    de    = 1'b0;
    rgb   = 24'h0;
    repeat (3) step();
    @(negedge clk);
    check_outputs_zero("reset");
    mon_on = 1'b1;
    step();
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (3) step();

    // exp_pulse, co_de, lines, pix, short_line, rst_line, en_drop, samp, fid
    frame(0, 1'b0, 8, 16, -1, -1, -1, 1'b1, 1);  // first frame after WAIT_VS: no pulse
    frame(1, 1'b0, 8, 16,  3, -1, -1, 1'b1, 2);  // closes good frame; this one has a 15-px line
    frame(2, 1'b0, 9, 20, -1, -1, -1, 1'b1, 3);  // closes short-line frame; oversize frame
    frame(2, 1'b0, 8, 16, -1, -1,  3, 1'b1, 4);  // closes oversize frame; en dropped at line 3
    frame(1, 1'b0, 8, 16, -1, -1, -1, 1'b0, 5);  // closes en-drop frame, block idle
    step();
    en = 1'b1;
    repeat (3) step();
    frame(0, 1'b0, 8, 16, -1,  5, -1, 1'b1, 6);  // reset at line 5
    frame(0, 1'b0, 8, 16, -1, -1, -1, 1'b1, 7);  // restart after reset: no pulse
    frame(1, 1'b1, 8, 16, -1, -1, -1, 1'b1, 8);  // vs rise coincident with first pixel
    frame(1, 1'b0, 0, 16, -1, -1, -1, 1'b1, 9);  // closing vs only
    repeat (5) step();

    chk("samples_outstanding", sq.size(), 32'd0);
    chk("pulses_outstanding", pq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
